// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : Multi-port general-purpose register file. NRD combinational
//            read ports, two prioritised write ports, same-cycle write-to-read
//            bypass, post-reset hardware clear and write-collision flag.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we0,
    input  logic [ADDR_W-1:0]       waddr0,
    input  logic [DATA_W-1:0]       wdata0,
    input  logic                    we1,
    input  logic [ADDR_W-1:0]       waddr1,
    input  logic [DATA_W-1:0]       wdata1,
    input  logic [NRD-1:0]          re,
    input  logic [NRD*ADDR_W-1:0]   raddr,
    output logic [NRD*DATA_W-1:0]   rdata,
    output logic                    init_done,
    output logic                    wr_conflict
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] c_last_ptr = ADDR_W'(NREG - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic                init_done_q, init_done_d;
    logic                wr_conflict_q, wr_conflict_d;
    logic [DATA_W-1:0]   regs_q [NREG];
    logic [DATA_W-1:0]   regs_d [NREG];

    logic                w_we0_ok;
    logic                w_we1_ok;

    // Writes to register 0 are discarded when it is hard-wired to zero.
    assign w_we0_ok = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
    assign w_we1_ok = we1 && !((ZERO_REG != 0) && (waddr1 == '0));

    // Sequencer: walk the clear pointer across the array, then run forever.
    always_comb begin
        state_d       = state_q;
        clr_ptr_d     = clr_ptr_q;
        init_done_d   = init_done_q;
        wr_conflict_d = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (clr_ptr_q == c_last_ptr) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                init_done_d   = 1'b1;
                wr_conflict_d = we0 && we1 && (waddr0 == waddr1);
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_CLEAR;
            clr_ptr_q     <= '0;
            init_done_q   <= 1'b0;
            wr_conflict_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_ptr_q     <= clr_ptr_d;
            init_done_q   <= init_done_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // Array next value: clear one entry per cycle, else apply port 0 then
    // port 1 so that port 1 wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (rst) begin
            if (state_q == ST_CLEAR) begin
                regs_d[clr_ptr_q] = '0;
            end else begin
                if (w_we0_ok) regs_d[waddr0] = wdata0;
                if (w_we1_ok) regs_d[waddr1] = wdata1;
            end
        end
    end

    // Storage array; reset leaves contents alone, the clear pass zeroes it.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_ra;
            logic [DATA_W-1:0] w_rd;

            assign w_ra = raddr[gi*ADDR_W +: ADDR_W];

            // Read mux: blanked in reset/clear, then zero reg, then bypass.
            always_comb begin
                w_rd = regs_q[w_ra];
                if (!rst || (state_q != ST_RUN) || !re[gi]) begin
                    w_rd = '0;
                end else if ((ZERO_REG != 0) && (w_ra == '0)) begin
                    w_rd = '0;
                end else if (we1 && (waddr1 == w_ra)) begin
                    w_rd = wdata1;
                end else if (we0 && (waddr0 == w_ra)) begin
                    w_rd = wdata0;
                end
            end

            assign rdata[gi*DATA_W +: DATA_W] = w_rd;
        end
    endgenerate

    assign init_done   = init_done_q;
    assign wr_conflict = wr_conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Brief    : Self-checking bench for regfile_mp. Two instances share write
//            stimulus: a 4-read-port build with a hard-wired r0 and a
//            2-read-port build where r0 is an ordinary register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    logic         clk = 1'b0;
    logic         rst;
    logic         we0, we1;
    logic [4:0]   waddr0, waddr1;
    logic [31:0]  wdata0, wdata1;
    logic [3:0]   re4;
    logic [19:0]  raddr4;
    logic [127:0] rdata1;
    logic [63:0]  rdata0;
    logic         done1, done0, conf1, conf0;

    int checks = 0;
    int errors = 0;

    // Reference model: register contents plus clear progress.
    logic [31:0] m1 [32];
    logic [31:0] m0 [32];
    bit          mdone = 1'b0;
    int          mcnt  = 0;
    bit          mconf = 1'b0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREG(32), .NRD(4), .ZERO_REG(1)) dut1 (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re4), .raddr(raddr4), .rdata(rdata1),
        .init_done(done1), .wr_conflict(conf1)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREG(32), .NRD(2), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re4[1:0]), .raddr(raddr4[9:0]), .rdata(rdata0),
        .init_done(done0), .wr_conflict(conf0)
    );

    // Value register a holds once this cycle's writes land (later port wins).
    function automatic logic [31:0] nextval(logic [31:0] cur, int a, bit zr);
        logic [31:0] v;
        v = cur;
        if (zr && a == 0) return cur;
        if (we0 && int'(waddr0) == a) v = wdata0;
        if (we1 && int'(waddr1) == a) v = wdata1;
        return v;
    endfunction

    // Expected read: a live read sees the post-write value of the register.
    function automatic logic [31:0] exp_rd(bit zr, int p);
        int a;
        a = int'(raddr4[p*5 +: 5]);
        if (!rst || !mdone || !re4[p]) return 32'h0;
        if (zr && a == 0) return 32'h0;
        return zr ? nextval(m1[a], a, 1'b1) : nextval(m0[a], a, 1'b0);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            mcnt  = 0;
            mdone = 1'b0;
            mconf = 1'b0;
        end else if (!mdone) begin
            m1[mcnt] = 32'h0;
            m0[mcnt] = 32'h0;
            mcnt++;
            if (mcnt == 32) mdone = 1'b1;
            mconf = 1'b0;
        end else begin
            mconf = we0 && we1 && (waddr0 == waddr1);
            for (int a = 0; a < 32; a++) begin
                m1[a] = nextval(m1[a], a, 1'b1);
                m0[a] = nextval(m0[a], a, 1'b0);
            end
        end
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0;
        waddr0 = '0; waddr1 = '0;
        wdata0 = '0; wdata1 = '0;
        re4 = '0; raddr4 = '0;
    endtask

    task automatic set_rd(int p, int a);
        logic [4:0] a5;
        a5 = a[4:0];
        raddr4[p*5 +: 5] = a5;
        re4[p] = 1'b1;
    endtask

    // Counts edges after reset release until init_done, bounded.
    task automatic wait_init(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done1 && n < 100);
    endtask

    task automatic test_reset();
        int n;
        idle();
        rst = 1'b0;
        re4 = 4'hF; raddr4 = 20'h8A4C3;
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h1;
        tick();
        #1;
        checks++; if (rdata1 !== 128'h0) begin errors++; $display("FAIL reset_rdata1: got %h exp 0", rdata1); end
        checks++; if (rdata0 !== 64'h0) begin errors++; $display("FAIL reset_rdata0: got %h exp 0", rdata0); end
        tick();
        checks++; if (done1 !== 1'b0 || conf1 !== 1'b0) begin errors++; $display("FAIL reset_flags: got done=%b conf=%b exp 0/0", done1, conf1); end
        idle();
        rst = 1'b1;
        wait_init(n);
        checks++; if (n != 32) begin errors++; $display("FAIL reset_init_latency: got %0d exp 32", n); end
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL reset_done0: got %b exp 1", done0); end
    endtask

    task automatic test_clear_after_write();
        int n;
        idle();
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        tick();
        we0 = 1'b0;
        set_rd(2, 5);
        #1;
        checks++; if (rdata1[95:64] !== 32'hDEADBEEF) begin errors++; $display("FAIL r5_before: got %h exp deadbeef", rdata1[95:64]); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        wait_init(n);
        checks++; if (n != 32) begin errors++; $display("FAIL reclear_latency: got %0d exp 32", n); end
        #1;
        checks++; if (rdata1[95:64] !== 32'h0) begin errors++; $display("FAIL r5_after_clear: got %h exp 0", rdata1[95:64]); end
    endtask

    task automatic test_write_during_clear();
        int n;
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h77;
        set_rd(0, 3);
        #1;
        checks++; if (rdata1[31:0] !== 32'h0) begin errors++; $display("FAIL clear_read_blank: got %h exp 0", rdata1[31:0]); end
        tick();
        we0 = 1'b0;
        checks++; if (conf1 !== 1'b0) begin errors++; $display("FAIL clear_conflict: got %b exp 0", conf1); end
        wait_init(n);
        checks++; if (n != 30) begin errors++; $display("FAIL clear_remaining: got %0d exp 30", n); end
        #1;
        checks++; if (rdata1[31:0] !== 32'h0) begin errors++; $display("FAIL r3_ignored: got %h exp 0", rdata1[31:0]); end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        logic [31:0] exp [4];
        exp = '{32'h11110001, 32'h22220002, 32'h33330003, 32'h44440004};
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (10) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        wait_init(n);
        checks++; if (n != 32) begin errors++; $display("FAIL midclear_latency: got %0d exp 32", n); end
        we0 = 1'b1; waddr0 = 5'd1; wdata0 = exp[0];
        we1 = 1'b1; waddr1 = 5'd2; wdata1 = exp[1];
        tick();
        waddr0 = 5'd3; wdata0 = exp[2];
        waddr1 = 5'd4; wdata1 = exp[3];
        tick();
        idle();
        for (int p = 0; p < 4; p++) set_rd(p, p + 1);
        #1;
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (rdata1[p*32 +: 32] !== exp[p]) begin errors++; $display("FAIL multiport_p%0d: got %h exp %h", p, rdata1[p*32 +: 32], exp[p]); end
        end
    endtask

    task automatic test_bypass();
        idle();
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h1234;
        set_rd(0, 7);
        #1;
        checks++; if (rdata1[31:0] !== 32'h1234) begin errors++; $display("FAIL bypass_same_cycle: got %h exp 1234", rdata1[31:0]); end
        checks++; if (rdata0[31:0] !== 32'h1234) begin errors++; $display("FAIL bypass_same_cycle_z0: got %h exp 1234", rdata0[31:0]); end
        tick();
        we0 = 1'b0;
        #1;
        checks++; if (rdata1[31:0] !== 32'h1234) begin errors++; $display("FAIL bypass_array: got %h exp 1234", rdata1[31:0]); end
    endtask

    task automatic test_collision();
        idle();
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'hAAAA;
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h5555;
        set_rd(0, 9); set_rd(1, 9);
        #1;
        checks++; if (rdata1[31:0] !== 32'h5555) begin errors++; $display("FAIL collide_bypass: got %h exp 5555", rdata1[31:0]); end
        checks++; if (rdata0[63:32] !== 32'h5555) begin errors++; $display("FAIL collide_bypass_z0: got %h exp 5555", rdata0[63:32]); end
        tick();
        we0 = 1'b0; we1 = 1'b0;
        checks++; if (conf1 !== 1'b1 || conf0 !== 1'b1) begin errors++; $display("FAIL collide_flag: got %b/%b exp 1/1", conf1, conf0); end
        #1;
        checks++; if (rdata1[31:0] !== 32'h5555) begin errors++; $display("FAIL collide_stored: got %h exp 5555", rdata1[31:0]); end
        tick();
        checks++; if (conf1 !== 1'b0) begin errors++; $display("FAIL collide_pulse_len: got %b exp 0", conf1); end
    endtask

    task automatic test_zero_reg();
        idle();
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
        for (int p = 0; p < 4; p++) set_rd(p, 0);
        #1;
        checks++; if (rdata1 !== 128'h0) begin errors++; $display("FAIL zero_reg_bypass: got %h exp 0", rdata1); end
        checks++; if (rdata0 !== {2{32'hFFFFFFFF}}) begin errors++; $display("FAIL r0_plain_bypass: got %h exp all ones", rdata0); end
        tick();
        we1 = 1'b0;
        #1;
        checks++; if (rdata1 !== 128'h0) begin errors++; $display("FAIL zero_reg_array: got %h exp 0", rdata1); end
        checks++; if (rdata0[31:0] !== 32'hFFFFFFFF) begin errors++; $display("FAIL r0_plain_array: got %h exp ffffffff", rdata0[31:0]); end
    endtask

    task automatic test_random();
        logic [31:0] e;
        for (int it = 0; it < 400; it++) begin
            we0 = 1'($urandom); we1 = 1'($urandom);
            waddr0 = ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom % 8);
            waddr1 = ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom % 8);
            wdata0 = $urandom; wdata1 = $urandom;
            re4 = 4'($urandom | 32'h1);
            for (int p = 0; p < 4; p++) raddr4[p*5 +: 5] = ($urandom % 3 == 0) ? 5'($urandom) : 5'($urandom % 8);
            #1;
            for (int p = 0; p < 4; p++) begin
                e = exp_rd(1'b1, p);
                checks++;
                if (rdata1[p*32 +: 32] !== e) begin errors++; $display("FAIL rand_rd1 it%0d p%0d: got %h exp %h", it, p, rdata1[p*32 +: 32], e); end
            end
            for (int p = 0; p < 2; p++) begin
                e = exp_rd(1'b0, p);
                checks++;
                if (rdata0[p*32 +: 32] !== e) begin errors++; $display("FAIL rand_rd0 it%0d p%0d: got %h exp %h", it, p, rdata0[p*32 +: 32], e); end
            end
            tick();
            checks++;
            if (conf1 !== mconf || conf0 !== mconf || done1 !== mdone) begin
                errors++;
                $display("FAIL rand_flags it%0d: got conf=%b/%b done=%b exp conf=%b done=%b", it, conf1, conf0, done1, mconf, mdone);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_clear_after_write();
        test_write_during_clear();
        test_reset_mid_clear();
        test_bypass();
        test_collision();
        test_zero_reg();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
